axi_rd_arbiter: RTL and testbench
=================================

// Module: axi_rd_arbiter
// PURPOSE
//  Shares the single AXI read master port (ar*_m / r*_m) among NREQ PageRank fetch engines
//  (vertex, in-edge, rank-read, ...). Address requests are granted round-robin and tagged with the
//  requester index in arid_m. Read beats are routed back by rid_m. A per-requester outstanding-burst
//  limit stops any one engine from flooding the memory. Sits between the engines and axi_emu / shell DRAM.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  IW       2   index bits carried in arid_m/rid_m LSBs; 2**IW >= NREQ
//  MAX_OUT  4   max outstanding (AR accepted, rlast not yet seen) bursts per requester
// PORTS
//  clk            in   1          clock, all logic on rising edge
//  rst            in   1          reset, asynchronous, active-high
//  req_arvalid    in   NREQ       per-requester read-address valid
//  req_arready    out  NREQ       per-requester grant (one-hot or zero)
//  req_araddr     in   NREQ*64    flattened byte addresses, requester i at [64*i +: 64]
//  req_arlen      in   NREQ*8     flattened burst lengths (beats-1)
//  arid_m         out  16         {zeros, grant index}
//  araddr_m       out  64         registered address
//  arlen_m        out  8          registered length
//  arsize_m       out  3          constant 3'b110 (64-byte beats)
//  arvalid_m      out  1          address valid to memory
//  arready_m      in   1          memory accepts address
//  rid_m          in   16         returning burst id
//  rdata_m        in   512        read data
//  rlast_m        in   1          last beat of burst
//  rvalid_m       in   1          read beat valid
//  rready_m       out  1          read beat accepted
//  req_rvalid     out  NREQ       routed beat valid
//  req_rdata      out  512        rdata_m broadcast to all requesters
//  req_rlast      out  1          rlast_m broadcast
//  req_rready     in   NREQ       per-requester beat accept
//  busy           out  1          any outstanding count nonzero, or arvalid_m high
//  rid_err        out  1          sticky: beat received with rid_m[IW-1:0] >= NREQ
// BEHAVIOUR
//  Reset (async, immediate): arvalid_m=0, araddr_m=0, arlen_m=0, arid_m=0, rid_err=0, RR pointer=0,
//   all outstanding counters=0, state=IDLE. req_arready forced 0 while rst high. In-flight bursts are lost.
//  AR FSM, 2 states:
//   IDLE: eligible(i) = req_arvalid[i] && cnt[i] < MAX_OUT. g = first eligible index at or after ptr,
//    wrapping modulo NREQ. If one exists: req_arready[g]=1 combinationally this cycle (handshake).
//    On the edge: latch araddr/arlen/arid=g, arvalid_m<=1, ptr<=(g+1)%NREQ, go to ISSUE.
//    With no eligible requester: ptr holds and state stays IDLE.
//   ISSUE: req_arready=0. araddr_m/arlen_m/arid_m stay stable while arvalid_m=1.
//    On arvalid_m && arready_m: arvalid_m<=0, cnt[arid]+=1, go to IDLE.
//    Back-to-back rate is therefore one AR per 2 cycles minimum.
//   Grant latency: request handshake in cycle t -> arvalid_m high in cycle t+1.
//  R path, fully combinational (no added latency):
//   k = rid_m[IW-1:0]
//   k < NREQ: req_rvalid[k] = rvalid_m; all others 0; rready_m = req_rready[k].
//   k >= NREQ: req_rvalid = 0; rready_m = 1 (drop beat); rid_err <= 1 on rvalid_m.
//   On rvalid_m && rready_m && rlast_m && k<NREQ: cnt[k] -= 1.
//  Counters are $clog2(MAX_OUT+1) bits wide.
//   Increment and decrement on the same requester in the same cycle: count unchanged.
//   Decrement at 0 is ignored, and the count saturates at 0.
//   The eligibility check guarantees no increment past MAX_OUT.
//  The arbiter places no ordering constraint across requesters.
//   R beats may interleave between ids; this block routes each beat independently.
// TESTING
//  1 NREQ=4: req0 addr 0x3E80 len 3 -> req_arready[0] same cycle; arvalid_m next cycle with araddr 0x3E80, arlen 3, arid 0; 4 beats rid 0 reach only req0; cnt0 1->0; busy drops.
//  2 req0..3 valid continuously, arready_m low 3 cycles per AR -> grants 0,1,2,3,0; address stable while stalled.
//  3 MAX_OUT=2, req1 issues 2 bursts with no R, req1+req2 valid -> req2 granted, req1 blocked; after rlast rid1, req1 granted next.
//  4 rvalid rid 2 with req_rready[2]=0 -> rready_m 0 held; same-cycle AR accept and rlast on id 2 -> cnt2 unchanged.
//  5 rvalid rid 7 -> rready_m 1, req_rvalid 0, rid_err 1 and it stays set.
//  6 rst asserted mid-clock while arvalid_m=1 and cnt0=2 -> arvalid_m, busy, and counts 0 before the next edge; first grant after release goes to req0.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin AR arbiter with per-requester outstanding limit
// and rid-based read-beat routing for the shared AXI read master port.
module axi_rd_arbiter #(
    parameter int NREQ    = 4,
    parameter int IW      = 2,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_arvalid,
    output logic [NREQ-1:0]   req_arready,
    input  logic [NREQ*64-1:0] req_araddr,
    input  logic [NREQ*8-1:0] req_arlen,
    output logic [15:0]       arid_m,
    output logic [63:0]       araddr_m,
    output logic [7:0]        arlen_m,
    output logic [2:0]        arsize_m,
    output logic              arvalid_m,
    input  logic              arready_m,
    input  logic [15:0]       rid_m,
    input  logic [511:0]      rdata_m,
    input  logic              rlast_m,
    input  logic              rvalid_m,
    output logic              rready_m,
    output logic [NREQ-1:0]   req_rvalid,
    output logic [511:0]      req_rdata,
    output logic              req_rlast,
    input  logic [NREQ-1:0]   req_rready,
    output logic              busy,
    output logic              rid_err
);

    localparam int CW = $clog2(MAX_OUT + 1);

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   arid_q, arid_d;
    logic [63:0]     araddr_q, araddr_d;
    logic [7:0]      arlen_q, arlen_d;
    logic            arvalid_q, arvalid_d;
    logic            rid_err_q, rid_err_d;
    logic [CW-1:0]   cnt_q [NREQ];
    logic [CW-1:0]   cnt_d [NREQ];

    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] gnt_oh;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_found;
    logic            ar_acc;
    logic [IW-1:0]   rk;
    logic            rk_ok;
    logic            r_fire_last;
    logic            unused_rid;

    assign rk          = rid_m[IW-1:0];
    assign rk_ok       = int'(rk) < NREQ;
    assign unused_rid  = ^rid_m;
    assign r_fire_last = rvalid_m && rready_m && rlast_m && rk_ok;

    assign arid_m    = {{(16 - IW){1'b0}}, arid_q};
    assign araddr_m  = araddr_q;
    assign arlen_m   = arlen_q;
    assign arsize_m  = 3'b110;
    assign arvalid_m = arvalid_q;
    assign rid_err   = rid_err_q;
    assign req_rdata = rdata_m;
    assign req_rlast = rlast_m;
    assign req_arready = rst ? '0 : gnt_oh;

    // Requesters below their outstanding-burst limit may compete.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = req_arvalid[i] && (cnt_q[i] < CW'(MAX_OUT));
        end
    end

    // Round-robin search: first eligible index at or after the pointer.
    always_comb begin
        int idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = int'(ptr_q) + off;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!gnt_found && elig[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = IW'(idx);
            end
        end
    end

    // AR FSM next state: grant in IDLE, hold the request stable in ISSUE.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        arid_d    = arid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arvalid_d = arvalid_q;
        gnt_oh    = '0;
        ar_acc    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    for (int i = 0; i < NREQ; i++) begin
                        gnt_oh[i] = (gnt_idx == IW'(i));
                    end
                    araddr_d  = req_araddr[64*int'(gnt_idx) +: 64];
                    arlen_d   = req_arlen[8*int'(gnt_idx) +: 8];
                    arid_d    = gnt_idx;
                    arvalid_d = 1'b1;
                    if (int'(gnt_idx) == NREQ - 1) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = gnt_idx + 1'b1;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (arvalid_q && arready_m) begin
                    arvalid_d = 1'b0;
                    ar_acc    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read beat routing by rid; unknown ids are drained and flagged.
    always_comb begin
        req_rvalid = '0;
        rready_m   = 1'b1;
        rid_err_d  = rid_err_q;
        if (rk_ok) begin
            for (int i = 0; i < NREQ; i++) begin
                if (rk == IW'(i)) begin
                    req_rvalid[i] = rvalid_m;
                    rready_m      = req_rready[i];
                end
            end
        end else if (rvalid_m) begin
            rid_err_d = 1'b1;
        end
    end

    // Outstanding counters: simultaneous issue and completion cancel out.
    always_comb begin
        busy = arvalid_q;
        for (int i = 0; i < NREQ; i++) begin
            logic inc;
            logic dec;
            inc = ar_acc && (arid_q == IW'(i));
            dec = r_fire_last && (rk == IW'(i));
            cnt_d[i] = cnt_q[i];
            if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (dec && !inc && cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
            if (cnt_q[i] != '0) begin
                busy = 1'b1;
            end
        end
    end

    // State, address register and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arvalid_q <= 1'b0;
            rid_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            arid_q    <= arid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arvalid_q <= arvalid_d;
            rid_err_q <= rid_err_d;
        end
    end

    // Per-requester outstanding-burst counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed scoreboard bench for axi_rd_arbiter
// (NREQ=4, IW=3 so out-of-range ids exist, MAX_OUT=2).
module tb_axi_rd_arbiter;

    localparam int NREQ    = 4;
    localparam int IW      = 3;
    localparam int MAX_OUT = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_arvalid;
    logic [NREQ-1:0]   req_arready;
    logic [NREQ*64-1:0] req_araddr;
    logic [NREQ*8-1:0] req_arlen;
    logic [15:0]       arid_m;
    logic [63:0]       araddr_m;
    logic [7:0]        arlen_m;
    logic [2:0]        arsize_m;
    logic              arvalid_m;
    logic              arready_m;
    logic [15:0]       rid_m;
    logic [511:0]      rdata_m;
    logic              rlast_m;
    logic              rvalid_m;
    logic              rready_m;
    logic [NREQ-1:0]   req_rvalid;
    logic [511:0]      req_rdata;
    logic              req_rlast;
    logic [NREQ-1:0]   req_rready;
    logic              busy;
    logic              rid_err;

    axi_rd_arbiter #(.NREQ(NREQ), .IW(IW), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst(rst),
        .req_arvalid(req_arvalid), .req_arready(req_arready),
        .req_araddr(req_araddr), .req_arlen(req_arlen),
        .arid_m(arid_m), .araddr_m(araddr_m), .arlen_m(arlen_m),
        .arsize_m(arsize_m), .arvalid_m(arvalid_m), .arready_m(arready_m),
        .rid_m(rid_m), .rdata_m(rdata_m), .rlast_m(rlast_m),
        .rvalid_m(rvalid_m), .rready_m(rready_m),
        .req_rvalid(req_rvalid), .req_rdata(req_rdata),
        .req_rlast(req_rlast), .req_rready(req_rready),
        .busy(busy), .rid_err(rid_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [63:0] addr;
        logic [7:0]  len;
    } ar_exp_t;

    typedef struct {
        int           idx;
        logic [511:0] data;
        logic         last;
    } r_exp_t;

    ar_exp_t ar_q[$];
    r_exp_t  r_q[$];
    ar_exp_t ae;
    r_exp_t  re;
    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [511:0] mkdata(input int n);
        logic [31:0] w;
        w = n;
        return {16{w}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [63:0] a, input logic [7:0] l);
        req_araddr[64*i +: 64] = a;
        req_arlen[8*i +: 8]    = l;
    endtask

    // grant cycle check + stalled ISSUE cycles + accept cycle
    task automatic grant(input int idx, input logic [63:0] a, input logic [7:0] l,
                         input int stalls);
        #1;
        check("gnt_onehot", req_arready, 64'(1) << idx);
        ar_q.push_back('{id: idx, addr: a, len: l});
        tick();
        for (int s = 0; s < stalls; s++) begin
            check("stall_valid", arvalid_m, 1);
            check("stall_addr", araddr_m, a);
            check("stall_noarready", req_arready, 0);
            tick();
        end
        arready_m = 1'b1;
        tick();
        arready_m = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_arvalid = '0;
        arready_m = 1'b0;
        rvalid_m = 1'b0;
        rlast_m = 1'b0;
        req_rready = '0;
        rid_m = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // monitor: pops the scoreboard whenever the DUT completes a transfer
    always @(negedge clk) begin
        if (!rst && arvalid_m && arready_m) begin
            if (ar_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL ar_unexpected got id=%0h addr=%0h want none", arid_m, araddr_m);
            end else begin
                ae = ar_q.pop_front();
                check("ar_id", 64'(arid_m), 64'(ae.id));
                check("ar_addr", araddr_m, ae.addr);
                check("ar_len", 64'(arlen_m), 64'(ae.len));
                check("ar_size", 64'(arsize_m), 64'h6);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (req_rvalid[i] && req_rready[i]) begin
                if (r_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL r_unexpected got req=%0d want none", i);
                end else begin
                    re = r_q.pop_front();
                    check("r_idx", 64'(i), 64'(re.idx));
                    check("r_last", 64'(req_rlast), 64'(re.last));
                    total++;
                    if (req_rdata !== re.data) begin
                        bad++;
                        $display("FAIL r_data got=%0h want=%0h", req_rdata[63:0], re.data[63:0]);
                    end
                end
            end
        end
    end

    initial begin
        req_arvalid = '1;
        req_araddr  = '0;
        req_arlen   = '0;
        arready_m   = 1'b0;
        rid_m       = '0;
        rdata_m     = '0;
        rlast_m     = 1'b0;
        rvalid_m    = 1'b0;
        req_rready  = '0;
        tick();
        tick();

        // reset state
        check("rst_arvalid", arvalid_m, 0);
        check("rst_araddr", araddr_m, 0);
        check("rst_arlen", arlen_m, 0);
        check("rst_arid", arid_m, 0);
        check("rst_busy", busy, 0);
        check("rst_riderr", rid_err, 0);
        check("rst_arready", req_arready, 0);

        // single request, 4-beat burst
        req_arvalid = '0;
        rst = 1'b0;
        set_req(0, 64'h3E80, 8'd3);
        req_arvalid = 4'b0001;
        #1;
        check("t1_gnt", req_arready, 4'b0001);
        ar_q.push_back('{id: 0, addr: 64'h3E80, len: 8'd3});
        tick();
        req_arvalid = '0;
        #1;
        check("t1_arvalid", arvalid_m, 1);
        check("t1_araddr", araddr_m, 64'h3E80);
        check("t1_arlen", arlen_m, 3);
        check("t1_arid", arid_m, 0);
        check("t1_issue_noready", req_arready, 0);
        arready_m = 1'b1;
        tick();
        arready_m = 1'b0;
        check("t1_arvalid_drop", arvalid_m, 0);
        check("t1_busy_out", busy, 1);
        req_rready = 4'b1111;
        for (int b = 0; b < 4; b++) begin
            rid_m = 16'd0;
            rdata_m = mkdata(32'h100 + b);
            rlast_m = (b == 3);
            rvalid_m = 1'b1;
            r_q.push_back('{idx: 0, data: mkdata(32'h100 + b), last: (b == 3)});
            #1;
            check("t1_route", req_rvalid, 4'b0001);
            check("t1_rready", rready_m, 1);
            tick();
        end
        rvalid_m = 1'b0;
        rlast_m = 1'b0;
        req_rready = '0;
        #1;
        check("t1_busy_idle", busy, 0);

        // all four requesting, stalled memory: round-robin order
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 64'h1000 * (i + 1), 8'(i));
        end
        req_arvalid = 4'b1111;
        grant(0, 64'h1000, 8'd0, 3);
        grant(1, 64'h2000, 8'd1, 3);
        grant(2, 64'h3000, 8'd2, 3);
        grant(3, 64'h4000, 8'd3, 3);
        grant(0, 64'h1000, 8'd0, 3);
        req_arvalid = '0;

        // outstanding limit blocks req1, completion releases it
        do_reset();
        set_req(1, 64'h2200, 8'd1);
        set_req(2, 64'h3300, 8'd2);
        req_arvalid = 4'b0010;
        grant(1, 64'h2200, 8'd1, 0);
        grant(1, 64'h2200, 8'd1, 0);
        req_arvalid = 4'b0110;
        grant(2, 64'h3300, 8'd2, 0);
        req_arvalid = 4'b0010;
        #1;
        check("t3_blocked_a", req_arready, 0);
        tick();
        check("t3_blocked_b", req_arready, 0);
        rid_m = 16'd1;
        rdata_m = mkdata(32'h300);
        rlast_m = 1'b1;
        rvalid_m = 1'b1;
        req_rready = 4'b0010;
        r_q.push_back('{idx: 1, data: mkdata(32'h300), last: 1'b1});
        #1;
        check("t3_blocked_c", req_arready, 0);
        check("t3_route", req_rvalid, 4'b0010);
        tick();
        rvalid_m = 1'b0;
        rlast_m = 1'b0;
        req_rready = '0;
        grant(1, 64'h2200, 8'd1, 0);
        req_arvalid = '0;

        // backpressure on id 2; same-cycle issue and completion on id 2
        do_reset();
        set_req(2, 64'h4400, 8'd0);
        req_arvalid = 4'b0100;
        grant(2, 64'h4400, 8'd0, 0);
        req_arvalid = '0;
        rid_m = 16'd2;
        rdata_m = mkdata(32'h400);
        rlast_m = 1'b1;
        rvalid_m = 1'b1;
        req_rready = '0;
        #1;
        check("t4_rready_hold_a", rready_m, 0);
        check("t4_route", req_rvalid, 4'b0100);
        tick();
        check("t4_rready_hold_b", rready_m, 0);
        req_arvalid = 4'b0100;
        #1;
        check("t4_gnt", req_arready, 4'b0100);
        ar_q.push_back('{id: 2, addr: 64'h4400, len: 8'd0});
        tick();
        req_arvalid = '0;
        req_rready = 4'b0100;
        arready_m = 1'b1;
        r_q.push_back('{idx: 2, data: mkdata(32'h400), last: 1'b1});
        #1;
        check("t4_rready_go", rready_m, 1);
        tick();
        arready_m = 1'b0;
        rvalid_m = 1'b0;
        rlast_m = 1'b0;
        req_rready = '0;
        req_arvalid = 4'b0100;
        grant(2, 64'h4400, 8'd0, 0);
        #1;
        check("t4_limit", req_arready, 0);
        req_arvalid = '0;

        // unknown rid is drained and flagged sticky
        check("t5_err_before", rid_err, 0);
        rid_m = 16'd7;
        rdata_m = mkdata(32'h700);
        rlast_m = 1'b1;
        rvalid_m = 1'b1;
        req_rready = '0;
        #1;
        check("t5_rready", rready_m, 1);
        check("t5_noroute", req_rvalid, 0);
        tick();
        rvalid_m = 1'b0;
        rlast_m = 1'b0;
        rid_m = '0;
        check("t5_err_set", rid_err, 1);
        tick();
        tick();
        check("t5_err_sticky", rid_err, 1);

        // async reset mid-cycle while an AR is pending
        do_reset();
        set_req(0, 64'h5000, 8'd7);
        set_req(1, 64'h6000, 8'd1);
        req_arvalid = 4'b0001;
        grant(0, 64'h5000, 8'd7, 0);
        grant(0, 64'h5000, 8'd7, 0);
        req_arvalid = 4'b0010;
        #1;
        check("t6_gnt1", req_arready, 4'b0010);
        tick();
        req_arvalid = 4'b1111;
        #1;
        check("t6_pending", arvalid_m, 1);
        check("t6_busy_pre", busy, 1);
        rst = 1'b1;
        #1;
        check("t6_arvalid_rst", arvalid_m, 0);
        check("t6_busy_rst", busy, 0);
        check("t6_arready_rst", req_arready, 0);
        tick();
        rst = 1'b0;
        grant(0, 64'h5000, 8'd7, 0);
        req_arvalid = '0;
        tick();

        check("ar_queue_empty", ar_q.size(), 0);
        check("r_queue_empty", r_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
